// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage: funct3 access
// encodings, WB mux select values and the bus FSM state type.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic {
        IDLE       = 1'b0,
        WAIT_RDATA = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage (master) and the
// data memory (slave).
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/mem_load_align.sv
// Load formatter: picks the byte/halfword addressed by offset out of the
// returned word and sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // A halfword only ever sits in lane 0 or lane 2; offset[0] is ignored.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: data-memory access FSM, store lane steering
// and MEM/WB register. Optional macro MEM_MISALIGN_TRAP_EN flags misaligned accesses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_pc_plus_4_in,
    input  logic [31:0] mem_alu_result_in,
    input  logic [31:0] mem_reg_read_data2_in,
    input  logic [4:0]  mem_rd_addr_in,
    input  logic        mem_reg_write_en_in,
    input  logic [1:0]  mem_mem_to_reg_in,
    input  logic        mem_mem_read_en_in,
    input  logic        mem_mem_write_en_in,
    input  logic [2:0]  mem_funct3_in,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic [31:0] wb_pc_plus_4_out,
    output logic [31:0] wb_alu_result_out,
    output logic [31:0] wb_load_data_out,
    output logic [4:0]  wb_rd_addr_out,
    output logic        wb_reg_write_en_out,
    output logic [1:0]  wb_mem_to_reg_out,
    output logic        wb_misaligned_out
);

    mem_state_t  state, state_next;
    logic [1:0]  off;
    logic        access;
    logic        misaligned;
    logic [31:0] load_data;

    assign off    = mem_alu_result_in[1:0];
    assign access = mem_mem_read_en_in | mem_mem_write_en_in;

`ifdef MEM_MISALIGN_TRAP_EN
    logic is_half, is_word;
    assign is_half    = mem_mem_read_en_in ? ((mem_funct3_in == F3_LH) || (mem_funct3_in == F3_LHU))
                                           : (mem_funct3_in == F3_SH);
    assign is_word    = (mem_funct3_in == F3_LW);
    assign misaligned = access & ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign dmem.dmem_we   = mem_mem_write_en_in;
    assign dmem.dmem_addr = {mem_alu_result_in[31:2], 2'b00};

    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = mem_reg_read_data2_in;
        case (mem_funct3_in)
            F3_SB: begin
                dmem.dmem_be    = 4'b0001 << off;
                dmem.dmem_wdata = {4{mem_reg_read_data2_in[7:0]}};
            end
            F3_SH: begin
                dmem.dmem_be    = 4'b0011 << {off[1], 1'b0};
                dmem.dmem_wdata = {2{mem_reg_read_data2_in[15:0]}};
            end
            default: begin
                dmem.dmem_be    = 4'b1111;
                dmem.dmem_wdata = mem_reg_read_data2_in;
            end
        endcase
    end

    mem_load_align u_load_align (
        .rdata     (dmem.dmem_rdata),
        .offset    (off),
        .funct3    (mem_funct3_in),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A store finishes in its grant cycle; a load always waits for rvalid.
    always_comb begin
        state_next    = state;
        mem_stall     = 1'b0;
        dmem.dmem_req = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    dmem.dmem_req = 1'b1;
                    if (mem_mem_read_en_in) begin
                        mem_stall = 1'b1;
                        if (dmem.dmem_gnt) state_next = WAIT_RDATA;
                    end else begin
                        mem_stall = ~dmem.dmem_gnt;
                    end
                end
            end
            WAIT_RDATA: begin
                mem_stall = ~dmem.dmem_rvalid;
                if (dmem.dmem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stall cycles insert an all-zero bubble into WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || mem_stall) begin
            wb_pc_plus_4_out    <= '0;
            wb_alu_result_out   <= '0;
            wb_load_data_out    <= '0;
            wb_rd_addr_out      <= '0;
            wb_reg_write_en_out <= 1'b0;
            wb_mem_to_reg_out   <= '0;
            wb_misaligned_out   <= 1'b0;
        end else begin
            wb_pc_plus_4_out    <= mem_pc_plus_4_in;
            wb_alu_result_out   <= mem_alu_result_in;
            wb_load_data_out    <= (mem_mem_read_en_in && !misaligned) ? load_data : 32'd0;
            wb_rd_addr_out      <= mem_rd_addr_in;
            wb_reg_write_en_out <= mem_reg_write_en_in & ~misaligned;
            wb_mem_to_reg_out   <= mem_mem_to_reg_in;
            wb_misaligned_out   <= misaligned;
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline. Consumes the EX/MEM register outputs and performs loads and stores over a req/gnt/rvalid data-memory bus. Formats load data with byte-lane selection and sign/zero extension, and stalls the pipeline while an access is outstanding. Drives the MEM/WB register internally, feeding the WB stage directly.

## Interface
- No parameters; data path fixed at 32 bits.
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_pc_plus_4_in  in  32  return address for JAL/JALR
- mem_alu_result_in  in  32  effective address, or ALU result
- mem_reg_read_data2_in  in  32  store data
- mem_rd_addr_in  in  5  destination register
- mem_reg_write_en_in  in  1  register-file write enable
- mem_mem_to_reg_in  in  2  WB mux select, passed through
- mem_mem_read_en_in  in  1  load
- mem_mem_write_en_in  in  1  store
- mem_funct3_in  in  3  access size and signedness
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, {alu_result[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- wb_pc_plus_4_out, wb_alu_result_out, wb_load_data_out  out  32 each  to WB
- wb_rd_addr_out  out  5; wb_reg_write_en_out  out  1; wb_mem_to_reg_out  out  2
- wb_misaligned_out  out  1  misaligned-access flag, one cycle

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- FSM states:
  - IDLE: default state.
  - WAIT_RDATA: a load has been granted and its data is pending.
- dmem_req = (read_en | write_en) & state==IDLE & ~misaligned. dmem_we = write_en.
- Transitions:
  - IDLE + load + gnt -> WAIT_RDATA.
  - WAIT_RDATA + rvalid -> IDLE.
  - A store granted in IDLE completes in that cycle and stays in IDLE.
- mem_stall is combinational:
  - IDLE: 1 for a load; 1 for a store while ~gnt.
  - WAIT_RDATA: 1 while ~rvalid.
  - Otherwise 0.
- Upstream holds all mem_*_in inputs stable while mem_stall=1.
- Store lanes, off = addr[1:0]:
  - SB (000): be = 0001<<off, wdata = {4{d[7:0]}}.
  - SH (001): be = 0011<<{off[1],0}, wdata = {2{d[15:0]}}.
  - SW (010): be = 1111, wdata = d.
  - Other funct3 values behave as SW.
- Loads: select byte/half by off from rdata.
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend.
  - LW (010) and any other funct3 return the whole word.
- MEM/WB register update on every clock:
  - Stall cycle: load a bubble (wb_reg_write_en_out=0, wb_misaligned_out=0); other fields don't-care.
  - Otherwise: capture all inputs; wb_load_data_out = formatted rdata for a load, else 0.
- rvalid in IDLE, and gnt in WAIT_RDATA, are ignored.

## Timing
- Reset: state=IDLE and all wb_* outputs 0. dmem_req drops immediately because its inputs are zero or held.
- Reset mid-load: the outstanding rvalid after reset is ignored.
- Latencies:
  - Non-memory op: wb_* valid 1 cycle after entry, no stall.
  - Store with gnt in the entry cycle: 1 cycle, no stall.
  - Load: minimum 2 cycles (gnt in cycle 0, rvalid in cycle 1); each extra wait cycle adds one stall cycle.
- The bus guarantees rvalid no earlier than one cycle after gnt, and at most one outstanding access.
- Back-to-back memory ops: the next request may issue in the cycle after completion.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0, issue no dmem_req and do not stall.
  - They complete in 1 cycle with wb_reg_write_en_out=0 and wb_misaligned_out=1.
- Undefined:
  - Offending low address bits are forced to 0: half uses {addr[1],0}, word uses lane 0.
  - The access proceeds normally; wb_misaligned_out is tied 0.

## Structure
- Shared package: funct3 load/store constants (F3_LB…F3_LHU), mem_to_reg encodings, FSM state typedef {IDLE, WAIT_RDATA}.
- Sub-module mem_load_align: combinational rdata + offset + funct3 -> 32-bit formatted load data.
- Store lane logic, FSM and MEM/WB register stay in the top.

## Test plan
- ALU op, alu_result=0x1234, rd=5, reg_write_en=1 -> next cycle wb_alu_result_out=0x1234, wb_rd_addr_out=5, mem_stall never 1.
- SB d=0xAABBCCDD at addr 0x103, gnt same cycle -> dmem_be=1000, dmem_wdata=0xDDDDDDDD, dmem_addr=0x100, no stall.
- LB at 0x102, gnt cycle 0, rvalid cycle 3, rdata=0x0080_0000:
  - mem_stall=1 in cycles 0–2.
  - wb_load_data_out=0xFFFFFF80 after cycle 3.
  - LBU same access -> 0x00000080.
- LH at 0x001 with macro -> no dmem_req, wb_misaligned_out=1, wb_reg_write_en_out=0. Without macro -> access with lane 0 halfword.
- SW with gnt held low 2 cycles -> dmem_req high 3 cycles, mem_stall=1 for 2, bubbles into WB.
- rst_n low in WAIT_RDATA, then rvalid after release -> state IDLE, wb_* stay 0, rvalid ignored.
